// File: rtl/sprite_pkg.sv
// Package: sprite_pkg
// Shared types and constants for the sprite palette scheduler.
//   rgb_t           - packed {r, g, b} colour, 8 bits per channel
//   PALETTE         - shared 16-entry sprite palette. Entries 0..8 hold colours and 9..15 are black.
//                     Entry 0 is never displayed because index 0 means transparent.
//   TRANSPARENT_IDX - palette index treated as "no pixel" for a layer
//   flash_state_e   - hit-flash FSM states
package sprite_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

  localparam rgb_t PALETTE [16] = '{
    '{r: 8'h00, g: 8'h00, b: 8'h00},  // 0 transparent, never shown
    '{r: 8'hF0, g: 8'hF0, b: 8'hF0},  // 1 light grey
    '{r: 8'hFF, g: 8'h00, b: 8'h00},  // 2 red
    '{r: 8'hE9, g: 8'h00, b: 8'h44},  // 3 enemy magenta
    '{r: 8'h00, g: 8'hFF, b: 8'h00},  // 4 green
    '{r: 8'h00, g: 8'h00, b: 8'hFF},  // 5 blue
    '{r: 8'hFF, g: 8'hFF, b: 8'h00},  // 6 yellow
    '{r: 8'h00, g: 8'hFF, b: 8'hFF},  // 7 cyan
    '{r: 8'h80, g: 8'h80, b: 8'h80},  // 8 mid grey
    '{r: 8'h00, g: 8'h00, b: 8'h00},
    '{r: 8'h00, g: 8'h00, b: 8'h00},
    '{r: 8'h00, g: 8'h00, b: 8'h00},
    '{r: 8'h00, g: 8'h00, b: 8'h00},
    '{r: 8'h00, g: 8'h00, b: 8'h00},
    '{r: 8'h00, g: 8'h00, b: 8'h00},
    '{r: 8'h00, g: 8'h00, b: 8'h00}
  };

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLASH_ON  = 2'd1,
    FLASH_OFF = 2'd2
  } flash_state_e;

endpackage

// File: rtl/hit_flash_fsm.sv
// Module: hit_flash_fsm
// Sequences the enemy hit-flash across frames. A hit starts or restarts the flash in FLASH_ON.
// Each frame_start advances a frame counter and a phase counter.
// The state toggles ON/OFF every FLASH_PERIOD frames.
// The FSM returns to IDLE after FLASH_FRAMES frame starts.
// This module only exists when the HIT_FLASH_EN macro is defined.
// Ports:
//   Clk         in  pixel clock
//   Reset_n     in  asynchronous reset, active low
//   frame_start in  one-cycle pulse at the start of each frame
//   hit         in  one-cycle pulse, restarts the flash (wins over frame_start)
//   override    out palette override active (FLASH_ON)
//   flashing    out flash in progress (FLASH_ON or FLASH_OFF)
`ifdef HIT_FLASH_EN
module hit_flash_fsm
  import sprite_pkg::*;
#(
  parameter int FLASH_FRAMES = 30,
  parameter int FLASH_PERIOD = 4
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_start,
  input  logic hit,
  output logic override,
  output logic flashing
);

  // Counters need at least one bit even when the period or length is 1.
  localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int PW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FLASH_FRAMES - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(FLASH_PERIOD - 1);

  if (FLASH_FRAMES < 1 || FLASH_PERIOD < 1) begin : g_bad_params
    $error("hit_flash_fsm: FLASH_FRAMES and FLASH_PERIOD must both be >= 1");
  end

  flash_state_e    state, state_next;
  logic [FW-1:0]   frame_cnt, frame_next;
  logic [PW-1:0]   phase_cnt, phase_next;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      frame_cnt <= '0;
      phase_cnt <= '0;
    end else begin
      state     <= state_next;
      frame_cnt <= frame_next;
      phase_cnt <= phase_next;
    end
  end

  // A hit always restarts the flash, even in the same cycle as a frame_start.
  // The last frame of the flash wins over a phase toggle.
  always_comb begin
    state_next = state;
    frame_next = frame_cnt;
    phase_next = phase_cnt;
    if (hit) begin
      state_next = FLASH_ON;
      frame_next = '0;
      phase_next = '0;
    end else if (frame_start && state != IDLE) begin
      if (frame_cnt == FRAME_LAST) begin
        state_next = IDLE;
        frame_next = '0;
        phase_next = '0;
      end else begin
        frame_next = frame_cnt + FW'(1);
        if (phase_cnt == PHASE_LAST) begin
          phase_next = '0;
          state_next = (state == FLASH_ON) ? FLASH_OFF : FLASH_ON;
        end else begin
          phase_next = phase_cnt + PW'(1);
        end
      end
    end
  end

  assign override = (state == FLASH_ON);
  assign flashing = (state != IDLE);

endmodule
`endif

// File: rtl/sprite_palette_sched.sv
// Module: sprite_palette_sched
// Per-pixel scheduler for the shared sprite palette.
// Stage 1 picks the highest-priority opaque layer, where the lowest layer number wins and index 0 is transparent.
// Stage 2 looks the winner up in the palette, or uses the background colour.
// During the ON phase of a hit flash, stage 2 forces white on HIT_LAYER.
// Latency is 2 cycles and throughput is one pixel per cycle.
// Build option: define HIT_FLASH_EN to build the hit-flash FSM.
// Without it, hit is ignored, flashing is 0 and the palette output is never overridden.
// Ports:
//   Clk, Reset_n       pixel clock, asynchronous active-low reset
//   pixel_en           a pixel is presented this cycle
//   frame_start        frame start pulse (advances the flash)
//   layer_valid        per-layer coverage of the current pixel
//   layer_idx          per-layer palette index, layer n at [n*IDX_W +: IDX_W]
//   bg_rgb             background colour {R,G,B}
//   hit                HIT_LAYER sprite was hit
//   red, green, blue   output colour
//   rgb_valid          output colour belongs to a pixel_en two cycles earlier
//   win_layer          winning layer, NUM_LAYERS means background
//   flashing           hit flash in progress
module sprite_palette_sched
  import sprite_pkg::*;
#(
  parameter int NUM_LAYERS   = 4,
  parameter int IDX_W        = 4,
  parameter int HIT_LAYER    = 1,
  parameter int FLASH_FRAMES = 30,
  parameter int FLASH_PERIOD = 4
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          pixel_en,
  input  logic                          frame_start,
  input  logic [NUM_LAYERS-1:0]         layer_valid,
  input  logic [NUM_LAYERS*IDX_W-1:0]   layer_idx,
  input  logic [23:0]                   bg_rgb,
  input  logic                          hit,
  output logic [7:0]                    red,
  output logic [7:0]                    green,
  output logic [7:0]                    blue,
  output logic                          rgb_valid,
  output logic [$clog2(NUM_LAYERS):0]   win_layer,
  output logic                          flashing
);

  localparam int LW = $clog2(NUM_LAYERS) + 1;
  localparam logic [LW-1:0] BG_LAYER = LW'(NUM_LAYERS);
  localparam logic [LW-1:0] HIT_SEL  = LW'(HIT_LAYER);

  if (IDX_W < 1 || IDX_W > 4 || NUM_LAYERS < 1) begin : g_bad_params
    $error("sprite_palette_sched: IDX_W must be 1..4 and NUM_LAYERS >= 1");
  end

  logic override;

  // Stage 1 combinational priority pick.
  // The first opaque layer in ascending order wins.
  logic             found_c;
  logic [LW-1:0]    layer_c;
  logic [IDX_W-1:0] idx_c;

  always_comb begin
    found_c = 1'b0;
    layer_c = BG_LAYER;
    idx_c   = '0;
    for (int n = 0; n < NUM_LAYERS; n++) begin
      if (!found_c && layer_valid[n] &&
          (layer_idx[n*IDX_W +: IDX_W] != IDX_W'(TRANSPARENT_IDX))) begin
        found_c = 1'b1;
        layer_c = LW'(n);
        idx_c   = layer_idx[n*IDX_W +: IDX_W];
      end
    end
  end

  // Stage 1 registers.
  // bg_rgb is captured alongside the winner so the background colour stays aligned with its pixel.
  logic             s1_valid;
  logic             s1_bg;
  logic [LW-1:0]    s1_layer;
  logic [IDX_W-1:0] s1_idx;
  rgb_t             s1_bg_rgb;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid  <= 1'b0;
      s1_bg     <= 1'b0;
      s1_layer  <= BG_LAYER;
      s1_idx    <= '0;
      s1_bg_rgb <= '0;
    end else begin
      s1_valid  <= pixel_en;
      s1_bg     <= !found_c;
      s1_layer  <= layer_c;
      s1_idx    <= idx_c;
      s1_bg_rgb <= rgb_t'(bg_rgb);
    end
  end

  // Stage 2 colour selection.
  // The flash override is sampled here, so it applies to the pixel as it leaves the pipeline.
  logic [3:0] pal_idx;
  rgb_t       pix_c;

  assign pal_idx = 4'(s1_idx);

  always_comb begin
    pix_c = PALETTE[pal_idx];
    if (s1_bg) begin
      pix_c = s1_bg_rgb;
    end else if (override && (s1_layer == HIT_SEL)) begin
      pix_c = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      red       <= 8'h00;
      green     <= 8'h00;
      blue      <= 8'h00;
      rgb_valid <= 1'b0;
      win_layer <= BG_LAYER;
    end else begin
      red       <= pix_c.r;
      green     <= pix_c.g;
      blue      <= pix_c.b;
      rgb_valid <= s1_valid;
      win_layer <= s1_layer;
    end
  end

`ifdef HIT_FLASH_EN
  hit_flash_fsm #(
    .FLASH_FRAMES(FLASH_FRAMES),
    .FLASH_PERIOD(FLASH_PERIOD)
  ) u_flash (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .hit         (hit),
    .override    (override),
    .flashing    (flashing)
  );
`else
  logic unused_flash_inputs;
  assign unused_flash_inputs = ^{hit, frame_start};
  assign override = 1'b0;
  assign flashing = 1'b0;
`endif

endmodule
